// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a start/stop sequencer that only changes the
// divided clock on period boundaries, and a valid/ready port for new divisors.
module clk_div_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             old_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             new_clock,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             new_clock_q, new_clock_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic active;
  logic wrap;
  logic accept;
  logic bad_div;

  assign active  = (state_q != IDLE);
  assign wrap    = active && (counter_q == div_q - WIDTH'(1));
  assign accept  = cfg_valid && !pend_q;
  assign bad_div = (cfg_div < WIDTH'(2));

  // NOTE: every _d gets its hold value first so no path through this block
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    div_d       = div_q;
    pend_div_d  = pend_div_q;
    pend_d      = pend_q;
    cfg_err_d   = 1'b0;
    new_clock_d = active && (counter_q < (div_q >> 1));
    tick_d      = active && (counter_q == '0);

    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        counter_d = wrap ? '0 : counter_q + WIDTH'(1);
        if (!enable) state_d = STOPPING;
      end
      STOPPING: begin
        counter_d = wrap ? '0 : counter_q + WIDTH'(1);
        // Re-enable wins over the stop so the waveform continues seamlessly.
        if (enable)    state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase

    if (wrap && pend_q) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end

    // Acceptance requires pend_q=0, so it never collides with an apply above.
    if (accept) begin
      if (bad_div) begin
        cfg_err_d = 1'b1;
      end else if (!active) begin
        div_d = cfg_div;
      end else begin
        pend_div_d = cfg_div;
        pend_d     = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge old_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      div_q       <= WIDTH'(DEFAULT_DIV);
      pend_div_q  <= '0;
      pend_q      <= 1'b0;
      new_clock_q <= 1'b0;
      tick_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      div_q       <= div_d;
      pend_div_q  <= pend_div_d;
      pend_q      <= pend_d;
      new_clock_q <= new_clock_d;
      tick_q      <= tick_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_ready = !pend_q;
  assign cfg_err   = cfg_err_q;
  assign new_clock = new_clock_q;
  assign tick      = tick_q;
  assign running   = active;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: start latency, waveform shape, divisor
// updates, rejected writes, stop/restart and asynchronous reset.
module tb_clk_div_ctrl;

  localparam int WIDTH = 32;

  logic             old_clock = 1'b0;
  logic             reset     = 1'b0;
  logic             enable    = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [WIDTH-1:0] cfg_div   = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             new_clock;
  logic             tick;
  logic             running;

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
    .old_clock (old_clock),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .new_clock (new_clock),
    .tick      (tick),
    .running   (running)
  );

  always #5 old_clock = ~old_clock;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge old_clock);
    #1;
  endtask

  // Returns once tick is seen; afterwards the internal counter is 1.
  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      step();
      if (tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_wait_tick: tick not seen within 30 cycles", name);
    end
  endtask

  task automatic go_idle(input string name);
    bit idle = 1'b0;
    enable = 1'b0;
    for (int n = 0; n < 40 && !idle; n++) begin
      step();
      if (running === 1'b0) idle = 1'b1;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL %s_go_idle: running still %b after 40 cycles", name, running);
    end
    step();
  endtask

  task automatic idle_write(input logic [WIDTH-1:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
  endtask

  // Checks one sample at phase i of a running waveform with divisor d.
  task automatic check_wave(input string name, input int i, input int d);
    logic exp_nc, exp_tk;
    exp_nc = ((i % d) < (d / 2));
    exp_tk = ((i % d) == 0);
    checks++;
    if (new_clock !== exp_nc || tick !== exp_tk || running !== 1'b1) begin
      errors++;
      $display("FAIL %s[%0d]: new_clock=%b tick=%b running=%b expected %b %b 1",
               name, i, new_clock, tick, running, exp_nc, exp_tk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if (new_clock !== 1'b0 || tick !== 1'b0 || cfg_err !== 1'b0 ||
        cfg_ready !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: nc=%b tick=%b err=%b ready=%b run=%b expected 0 0 0 1 0",
               new_clock, tick, cfg_err, cfg_ready, running);
    end
    reset = 1'b1;
    step();
    step();
    checks++;
    if (running !== 1'b0 || new_clock !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: running=%b nc=%b expected 0 0", running, new_clock);
    end
  endtask

  task automatic test_default_div();
    enable = 1'b1;
    step();
    checks++;
    if (running !== 1'b1 || new_clock !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL start_edge1: running=%b nc=%b tick=%b expected 1 0 0",
               running, new_clock, tick);
    end
    step();
    checks++;
    if (tick !== 1'b1 || new_clock !== 1'b1) begin
      errors++;
      $display("FAIL start_edge2: tick=%b nc=%b expected 1 1", tick, new_clock);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      check_wave("div4_wave", i, 4);
    end
    go_idle("default");
  endtask

  task automatic test_idle_write();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready_before: cfg_ready=%b expected 1", cfg_ready);
    end
    idle_write(WIDTH'(5));
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready_after: cfg_ready=%b expected 1", cfg_ready);
    end
    enable = 1'b1;
    step();
    wait_tick("div5");
    for (int i = 1; i <= 15; i++) begin
      step();
      check_wave("div5_wave", i, 5);
      checks++;
      if (cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL div5_ready[%0d]: cfg_ready=%b expected 1", i, cfg_ready);
      end
    end
    go_idle("div5");
    idle_write(WIDTH'(4));
  endtask

  task automatic test_running_write();
    logic exp_rdy;
    enable = 1'b1;
    wait_tick("runwr");
    // Counter is 1 here: the write is accepted on the edge that sees counter=1.
    cfg_valid = 1'b1;
    cfg_div   = WIDTH'(6);
    for (int i = 1; i <= 3; i++) begin
      step();
      cfg_valid = 1'b0;
      check_wave("runwr_old", i, 4);
      exp_rdy = (i == 3);
      checks++;
      if (cfg_ready !== exp_rdy) begin
        errors++;
        $display("FAIL runwr_ready[%0d]: cfg_ready=%b expected %b", i, cfg_ready, exp_rdy);
      end
    end
    for (int j = 0; j < 12; j++) begin
      step();
      check_wave("runwr_div6", j, 6);
    end
    go_idle("runwr");
    idle_write(WIDTH'(4));
  endtask

  task automatic test_bad_writes();
    logic exp_err;
    enable = 1'b1;
    wait_tick("bad");
    for (int i = 1; i <= 16; i++) begin
      cfg_valid = (i == 3 || i == 7);
      cfg_div   = (i == 3) ? WIDTH'(0) : WIDTH'(1);
      step();
      check_wave("bad_wave", i, 4);
      exp_err = (i == 3 || i == 7);
      checks++;
      if (cfg_err !== exp_err || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL bad_err[%0d]: cfg_err=%b ready=%b expected %b 1",
                 i, cfg_err, cfg_ready, exp_err);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_stop_restart();
    logic exp_nc, exp_run;
    wait_tick("stop");
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_nc  = (i == 1);
      exp_run = (i <= 2);
      checks++;
      if (new_clock !== exp_nc || running !== exp_run || tick !== 1'b0) begin
        errors++;
        $display("FAIL stop[%0d]: nc=%b running=%b tick=%b expected %b %b 0",
                 i, new_clock, running, tick, exp_nc, exp_run);
      end
    end
    enable = 1'b1;
    step();
    wait_tick("restart");
    for (int i = 1; i <= 12; i++) begin
      enable = (i != 1);
      step();
      check_wave("reenable_wave", i, 4);
    end
  endtask

  task automatic test_reset_mid();
    go_idle("rstmid");
    idle_write(WIDTH'(6));
    enable = 1'b1;
    wait_tick("rstmid");
    cfg_valid = 1'b1;
    cfg_div   = WIDTH'(8);
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pending: cfg_ready=%b expected 0", cfg_ready);
    end
    step();
    enable = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (new_clock !== 1'b0 || cfg_ready !== 1'b1 || running !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: nc=%b ready=%b running=%b tick=%b expected 0 1 0 0",
               new_clock, cfg_ready, running, tick);
    end
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (running !== 1'b0 || new_clock !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_hold[%0d]: running=%b nc=%b expected 0 0", i, running, new_clock);
      end
    end
    enable = 1'b1;
    step();
    step();
    checks++;
    if (tick !== 1'b1 || new_clock !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_start: tick=%b nc=%b expected 1 1", tick, new_clock);
    end
    for (int i = 1; i <= 16; i++) begin
      step();
      check_wave("rstmid_div4", i, 4);
      checks++;
      if (cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_ready[%0d]: cfg_ready=%b expected 1", i, cfg_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_idle_write();
    test_running_write();
    test_bad_writes();
    test_stop_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the divided clock. It owns a programmable divide counter and a three-state sequencer that starts and stops the divided clock only on period boundaries. It accepts new divisor values through a valid/ready handshake and applies them glitch-free at the next period wrap. It sits between the system clock and the slow-clock consumers, and gives the rest of the design a registered divided clock plus a one-cycle period tick.

## Interface
- WIDTH, 32: divide counter and divisor width.
- DEFAULT_DIV, 4: divisor loaded at reset; must be ≥2.
- old_clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset; high when not in reset.
- enable  in  1  level; request the divided clock to run.
- cfg_valid  in  1  divisor write request.
- cfg_div  in  WIDTH  requested divisor; legal range 2..2^WIDTH-1.
- cfg_ready  out  1  high when a write can be accepted.
- cfg_err  out  1  one-cycle pulse when a write of cfg_div<2 is rejected.
- new_clock  out  1  registered divided clock.
- tick  out  1  one-cycle pulse coincident with each new_clock rising period start.
- running  out  1  high when state is not IDLE.

## Operation
- Registers:
  - state: IDLE, RUN or STOPPING.
  - counter[WIDTH-1:0].
  - div_reg[WIDTH-1:0].
  - pend_div[WIDTH-1:0] and pend flag.
  - Registered outputs new_clock, tick and cfg_err.
- Reset values: state=IDLE, counter=0, div_reg=DEFAULT_DIV, pend=0, new_clock=0, tick=0, cfg_err=0, cfg_ready=1, running=0.
- wrap = (counter == div_reg-1), evaluated only when not IDLE.
- IDLE:
  - counter is held at 0.
  - enable=1 moves to RUN; counter stays 0 on that edge.
- RUN:
  - counter increments, and goes to 0 on wrap.
  - enable=0 moves to STOPPING (counter keeps counting).
- STOPPING:
  - Counting continues until wrap.
  - At wrap: go to IDLE, counter=0.
  - enable=1 before wrap returns to RUN with no break in the waveform.
- Outputs, each evaluated from the pre-edge counter:
  - new_clock <= (state≠IDLE) && (counter < div_reg>>1).
  - tick <= (state≠IDLE) && (counter == 0).
  - Odd divisors give floor(div/2) cycles high and ceil(div/2) cycles low.
- Handshake: a write is accepted when cfg_valid && cfg_ready. cfg_ready = !pend.
- Accepted writes:
  - cfg_div<2: rejected. cfg_err pulses on the next cycle; no register changes.
  - In IDLE: div_reg <= cfg_div on the accepting edge; pend stays 0.
  - In RUN or STOPPING: pend_div <= cfg_div and pend <= 1, so cfg_ready drops.
- Pending apply: at a wrap with pend=1, div_reg <= pend_div, pend <= 0 and counter <= 0. The new divisor governs the next period.
- Write accepted on the same edge as a wrap: it goes to pend (pend was 0) and applies at the following wrap, not the current one.
- Pending write when STOPPING reaches IDLE: it is applied on that same wrap edge.
- Arithmetic: counter and div_reg are unsigned WIDTH-bit. Compares are unsigned. No overflow is possible since counter < div_reg.

## Timing
- enable sampled high at edge k in IDLE: state=RUN after k. First tick and new_clock high after edge k+1 (2-cycle start latency).
- Period is exactly div_reg cycles. tick repeats every div_reg cycles, aligned to the new_clock rise.
- Stop: new_clock is low after the edge following the wrap. The last period is always complete (no runt pulse).
- cfg_ready low from the edge after acceptance until the edge that applies the pending value.
- Asynchronous reset mid-operation:
  - All registers go to their reset values immediately, and new_clock drops with no clock edge.
  - Any pending write is discarded.
  - After reset release, nothing runs until enable is sampled.

## Test plan
- Reset then enable=1, DEFAULT_DIV=4:
  - tick and new_clock rise 2 cycles after enable is sampled.
  - new_clock pattern is 1,1,0,0 repeating.
  - tick fires every 4 cycles; running=1.
- Write cfg_div=5 in IDLE, then enable:
  - new_clock is high 2 cycles, low 3 cycles; tick period 5.
  - cfg_ready never drops.
- Running at div=4, write cfg_div=6 while counter=1:
  - cfg_ready=0 until the wrap.
  - The current period completes at 4 cycles; subsequent periods are 6 cycles (3 high, 3 low).
  - cfg_ready=1 after the apply edge.
- Write cfg_div=0, then cfg_div=1:
  - Each write gives a single-cycle cfg_err pulse.
  - div_reg stays 4, and the waveform is unchanged.
- Running at div=4, enable=0 at counter=1:
  - The period finishes, then new_clock=0 and running=0.
  - Repeat with enable re-asserted at counter=2: no gap, and the tick cadence is unbroken.
- Running at div=6 with a pending write of 8, assert reset at counter=3:
  - new_clock=0 and cfg_ready=1 immediately.
  - After release and enable, the period is 4 (DEFAULT_DIV); the pending 8 is never applied.
